// File: rtl/dmac_master_engine.sv
// DMA master engine: pops descriptors from the DMAC FIFO and copies each one word by word
// over the shared master bus, holding the bus for the whole descriptor.
module dmac_master_engine #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_start,
  output logic          fifo_rd_en,
  input  logic          fifo_rd_ack,
  input  logic          fifo_rd_err,
  input  logic [AW-1:0] src_addr_in,
  input  logic [AW-1:0] dest_addr_in,
  input  logic [31:0]   data_size_in,
  output logic          m_req,
  input  logic          m_grant,
  output logic [AW-1:0] m_addr,
  output logic          m_wr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          op_done
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StPop     = 4'd1;
  localparam logic [3:0] StWaitAck = 4'd2;
  localparam logic [3:0] StReq     = 4'd3;
  localparam logic [3:0] StRd      = 4'd4;
  localparam logic [3:0] StRdWait  = 4'd5;
  localparam logic [3:0] StWr      = 4'd6;
  localparam logic [3:0] StRel     = 4'd7;
  localparam logic [3:0] StDone    = 4'd8;

  localparam logic [AW-1:0] AddrOne = {{(AW-1){1'b0}}, 1'b1};

  logic [3:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;

  // fifo_rd_err needs no explicit decode: anything other than an ack ends the queue.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (op_start) begin
          state_d = StPop;
          busy_d  = 1'b1;
        end
      end
      StPop: state_d = StWaitAck;
      StWaitAck: begin
        if (fifo_rd_ack) begin
          src_d   = src_addr_in;
          dst_d   = dest_addr_in;
          cnt_d   = data_size_in;
          state_d = (data_size_in == 32'd0) ? StPop : StReq;
        end else begin
          state_d = StDone;
        end
      end
      StReq: if (m_grant) state_d = StRd;
      StRd:  if (m_grant) state_d = StRdWait;
      StRdWait: begin
        if (m_grant) begin
          data_d  = m_rdata;
          state_d = StWr;
        end
      end
      StWr: begin
        if (m_grant) begin
          src_d   = src_q + AddrOne;
          dst_d   = dst_q + AddrOne;
          cnt_d   = (cnt_q != 32'd0) ? cnt_q - 32'd1 : 32'd0;
          state_d = (cnt_q <= 32'd1) ? StRel : StRd;
        end
      end
      StRel: state_d = StPop;
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them immediately.
  always_comb begin
    fifo_rd_en = (state_q == StPop);
    op_done    = (state_q == StDone);
    busy       = busy_q;
    m_req      = (state_q == StReq) || (state_q == StRd) ||
                 (state_q == StRdWait) || (state_q == StWr);
    m_wr       = (state_q == StWr) && m_grant;
    m_wdata    = (state_q == StWr) ? data_q : '0;
    // Source address stays up through RD_WAIT so a stalled read can be re-fetched.
    case (state_q)
      StRd, StRdWait: m_addr = src_q;
      StWr:           m_addr = dst_q;
      default:        m_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_dmac_master_engine.sv
// Directed bench for dmac_master_engine with a descriptor FIFO model and split read/write memory.
module tb_dmac_master_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_start = 1'b0;
  logic        m_grant = 1'b1;
  logic        fifo_rd_ack = 1'b0;
  logic        fifo_rd_err = 1'b0;
  logic [31:0] src_addr_in = '0;
  logic [31:0] dest_addr_in = '0;
  logic [31:0] data_size_in = '0;
  logic [31:0] m_rdata = '0;
  logic        fifo_rd_en, m_req, m_wr, busy, op_done;
  logic [31:0] m_addr, m_wdata;

  dmac_master_engine #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_ack  (fifo_rd_ack),
    .fifo_rd_err  (fifo_rd_err),
    .src_addr_in  (src_addr_in),
    .dest_addr_in (dest_addr_in),
    .data_size_in (data_size_in),
    .m_req        (m_req),
    .m_grant      (m_grant),
    .m_addr       (m_addr),
    .m_wr         (m_wr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .busy         (busy),
    .op_done      (op_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Descriptor FIFO: answers a pop in the following cycle with ack or err.
  logic [31:0] q_src [16];
  logic [31:0] q_dst [16];
  logic [31:0] q_sz  [16];
  int q_wr = 0;
  int q_rd = 0;

  always @(posedge clk) begin
    fifo_rd_ack <= 1'b0;
    fifo_rd_err <= 1'b0;
    if (fifo_rd_en) begin
      if (q_rd != q_wr) begin
        fifo_rd_ack  <= 1'b1;
        src_addr_in  <= q_src[q_rd % 16];
        dest_addr_in <= q_dst[q_rd % 16];
        data_size_in <= q_sz[q_rd % 16];
        q_rd         <= q_rd + 1;
      end else begin
        fifo_rd_err <= 1'b1;
      end
    end
  end

  // Reads come from rom (preloaded by tests), writes land in ram.
  logic [31:0] rom [256];
  logic [31:0] ram [256];

  always @(posedge clk) begin
    if (m_req && m_grant && !m_wr) m_rdata <= rom[m_addr[7:0]];
    if (m_wr) ram[m_addr[7:0]] <= m_wdata;
  end

  int n_rden = 0, n_done = 0, n_req = 0, n_stall_wr = 0;
  int cyc = 0, rden_cyc = 0, done_cyc = 0;
  logic [31:0] wlog [$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_rd_en) begin
      n_rden   = n_rden + 1;
      rden_cyc = cyc;
    end
    if (op_done) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
    end
    if (m_req) n_req = n_req + 1;
    if (m_wr) wlog.push_back(m_addr);
    if (m_wr && !m_grant) n_stall_wr = n_stall_wr + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    q_src[q_wr % 16] = s;
    q_dst[q_wr % 16] = d;
    q_sz[q_wr % 16]  = n;
    q_wr = q_wr + 1;
  endtask

  task automatic start_op();
    op_start = 1'b1;
    step();
    op_start = 1'b0;
  endtask

  task automatic run_op(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [69:0] outs;
    for (int i = 0; i < 4; i++) begin
      op_start = 1'($urandom);
      m_grant  = 1'($urandom);
      step();
      outs = {fifo_rd_en, m_req, m_wr, busy, op_done, m_addr, m_wdata[0]};
      n_chk++;
      if (outs !== '0 || m_wdata !== 32'd0)
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, outs);
      else n_pass++;
    end
    op_start = 1'b0;
    m_grant  = 1'b1;
    reset    = 1'b0;
    step();
    n_chk++;
    if ({busy, fifo_rd_en, m_req} !== 3'b000)
      $display("FAIL reset_release: busy/rd_en/req=%b want 000", {busy, fifo_rd_en, m_req});
    else n_pass++;
    // Start, then hit reset mid-cycle while in POP.
    start_op();
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({busy, fifo_rd_en} !== 2'b00)
      $display("FAIL reset_async: busy/rd_en=%b want 00", {busy, fifo_rd_en});
    else n_pass++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_copy();
    logic [31:0] exp [3];
    int s_rden, s_done, s_req;
    bit ok;
    exp[0] = 32'hA000_000A; exp[1] = 32'hB000_000B; exp[2] = 32'hC000_000C;
    for (int i = 0; i < 3; i++) rom[8'h10 + i] = exp[i];
    push(32'h10, 32'h40, 32'd3);
    s_rden = n_rden; s_done = n_done; s_req = n_req;
    start_op();
    run_op(200, ok);
    n_chk++;
    if (!ok) $display("FAIL copy_timeout: busy still %b want 0", busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (ram[8'h40 + i] !== exp[i])
        $display("FAIL copy_word[%0d]: got %h want %h", i, ram[8'h40 + i], exp[i]);
      else n_pass++;
    end
    n_chk++;
    if (n_rden - s_rden != 2) $display("FAIL copy_pops: got %0d want 2", n_rden - s_rden);
    else n_pass++;
    n_chk++;
    if (n_done - s_done != 1) $display("FAIL copy_done: got %0d want 1", n_done - s_done);
    else n_pass++;
    n_chk++;
    if (n_req - s_req != 10) $display("FAIL copy_req_cycles: got %0d want 10", n_req - s_req);
    else n_pass++;
  endtask

  task automatic test_zero_size();
    int s_rden, s_done, s_req, s_w;
    bit ok;
    rom[8'h20] = 32'h1234_5678;
    push(32'h0, 32'h80, 32'd0);
    push(32'h20, 32'h90, 32'd1);
    s_rden = n_rden; s_done = n_done; s_req = n_req; s_w = wlog.size();
    start_op();
    run_op(200, ok);
    n_chk++;
    if (!ok) $display("FAIL zero_timeout: busy still %b want 0", busy); else n_pass++;
    n_chk++;
    if (ram[8'h90] !== 32'h1234_5678)
      $display("FAIL zero_word: got %h want 12345678", ram[8'h90]);
    else n_pass++;
    n_chk++;
    if (wlog.size() - s_w != 1 || wlog[s_w] !== 32'h90)
      $display("FAIL zero_writes: got %0d writes want 1 at 90", wlog.size() - s_w);
    else n_pass++;
    n_chk++;
    if (n_req - s_req != 4) $display("FAIL zero_req_cycles: got %0d want 4", n_req - s_req);
    else n_pass++;
    n_chk++;
    if (n_rden - s_rden != 3 || n_done - s_done != 1)
      $display("FAIL zero_pops_done: got %0d/%0d want 3/1", n_rden - s_rden, n_done - s_done);
    else n_pass++;
  endtask

  task automatic test_grant_stall();
    logic [31:0] exp [4];
    int s_w, s_stall;
    bit ok, seen;
    exp[0] = 32'h0000_1111; exp[1] = 32'h0000_2222;
    exp[2] = 32'h0000_3333; exp[3] = 32'h0000_4444;
    for (int i = 0; i < 4; i++) rom[8'h50 + i] = exp[i];
    push(32'h50, 32'h60, 32'd4);
    s_w = wlog.size(); s_stall = n_stall_wr;
    start_op();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (wlog.size() > s_w && m_req && !m_wr && m_addr == 32'h51) seen = 1'b1;
    end
    n_chk++;
    if (!seen) $display("FAIL stall_second_read: m_addr=%h want 51", m_addr); else n_pass++;
    step();
    m_grant = 1'b0;
    repeat (5) step();
    m_grant = 1'b1;
    run_op(200, ok);
    n_chk++;
    if (!ok) $display("FAIL stall_timeout: busy still %b want 0", busy); else n_pass++;
    n_chk++;
    if (n_stall_wr != s_stall)
      $display("FAIL stall_wr: got %0d writes without grant want 0", n_stall_wr - s_stall);
    else n_pass++;
    n_chk++;
    if (wlog.size() - s_w != 4)
      $display("FAIL stall_write_count: got %0d want 4", wlog.size() - s_w);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (ram[8'h60 + i] !== exp[i] || wlog[s_w + i] !== 32'h60 + i)
        $display("FAIL stall_word[%0d]: got %h at %h want %h at %h", i, ram[8'h60 + i],
                 wlog[s_w + i], exp[i], 32'h60 + i);
      else n_pass++;
    end
  endtask

  task automatic test_empty();
    int s_rden, s_done, s_req;
    bit ok;
    s_rden = n_rden; s_done = n_done; s_req = n_req;
    start_op();
    run_op(50, ok);
    n_chk++;
    if (!ok) $display("FAIL empty_timeout: busy still %b want 0", busy); else n_pass++;
    n_chk++;
    if (n_rden - s_rden != 1 || n_done - s_done != 1)
      $display("FAIL empty_pops_done: got %0d/%0d want 1/1", n_rden - s_rden, n_done - s_done);
    else n_pass++;
    n_chk++;
    if (done_cyc - rden_cyc != 2)
      $display("FAIL empty_done_latency: got %0d want 2", done_cyc - rden_cyc);
    else n_pass++;
    n_chk++;
    if (n_req != s_req) $display("FAIL empty_req: got %0d want 0", n_req - s_req);
    else n_pass++;
  endtask

  task automatic test_reset_mid_copy();
    int s_done;
    bit ok, seen;
    for (int i = 0; i < 8; i++) rom[8'h70 + i] = 32'hD000_0000 + i;
    rom[8'h30] = 32'hFACE_0001;
    rom[8'h31] = 32'hFACE_0002;
    push(32'h70, 32'hC0, 32'd8);
    s_done = n_done;
    start_op();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (m_wr) seen = 1'b1;
    end
    n_chk++;
    if (!seen) $display("FAIL midreset_find_wr: m_wr=%b want 1", m_wr); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({m_req, m_wr, busy, m_addr} !== 35'd0)
      $display("FAIL midreset_outputs: req/wr/busy=%b addr=%h want 0", {m_req, m_wr, busy}, m_addr);
    else n_pass++;
    step();
    reset = 1'b0;
    step();
    push(32'h30, 32'hB0, 32'd2);
    start_op();
    run_op(200, ok);
    n_chk++;
    if (!ok) $display("FAIL midreset_timeout: busy still %b want 0", busy); else n_pass++;
    n_chk++;
    if (ram[8'hB0] !== 32'hFACE_0001 || ram[8'hB1] !== 32'hFACE_0002)
      $display("FAIL midreset_copy: got %h %h want face0001 face0002", ram[8'hB0], ram[8'hB1]);
    else n_pass++;
    n_chk++;
    if (n_done - s_done != 1) $display("FAIL midreset_done: got %0d want 1", n_done - s_done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_copy();
    test_zero_size();
    test_grant_stall();
    test_empty();
    test_reset_mid_copy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
